// File: rtl/sumador_secuencial_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : sumador_secuencial_pkg
//  Description : Shared FSM encoding and sizing helpers for the multi-cycle
//                digit-serial adder/subtractor.
//  Revision    : 1.0 - initial release
// ============================================================================
package sumador_secuencial_pkg;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  // Number of digit steps needed to cover the full operand width.
  function automatic int calc_n(input int width, input int digit);
    return width / digit;
  endfunction

  // Digit counter width; never narrower than one bit so N=1 still builds.
  function automatic int calc_cnt_w(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage
`default_nettype wire

// File: rtl/sumador_digito.sv
`default_nettype none
// ============================================================================
//  Module      : sumador_digito
//  Description : Combinational DIGIT-bit adder with carry-in and carry-out.
//                Generalisation of the original fixed 4-bit adder.
//  Revision    : 1.0 - initial release
// ============================================================================
module sumador_digito #(
  parameter int DIGIT = 4
) (
  input  logic [DIGIT-1:0] A,
  input  logic [DIGIT-1:0] B,
  input  logic             Cin,
  output logic [DIGIT-1:0] Sum,
  output logic             Cout
);

  assign {Cout, Sum} = {1'b0, A} + {1'b0, B} + {{DIGIT{1'b0}}, Cin};

endmodule
`default_nettype wire

// File: rtl/sumador_secuencial.sv
`default_nettype none
// ============================================================================
//  Module      : sumador_secuencial
//  Description : Multi-cycle WIDTH-bit adder/subtractor. Processes DIGIT bits
//                per clock, least-significant digit first, with a start/done
//                handshake, carry-in, subtract mode and signed overflow flag.
//  Revision    : 1.0 - initial release
// ============================================================================
module sumador_secuencial
  import sumador_secuencial_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int DIGIT = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Cin,
  input  logic             Sub,
  output logic             ready,
  output logic             done,
  output logic [WIDTH-1:0] Sum,
  output logic             Cout,
  output logic             Ovf
);

  localparam int N  = calc_n(WIDTH, DIGIT);
  localparam int CW = calc_cnt_w(N);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;       // effective B (already inverted for Sub)
  logic             carry_q, carry_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             a_msb_q, a_msb_d;
  logic             b_msb_q, b_msb_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;
  logic             done_q, done_d;

  logic [DIGIT-1:0] w_dsum;
  logic             w_dcout;
  logic [WIDTH-1:0] w_full;         // completed result once the last digit lands
  logic             w_last;

  sumador_digito #(
    .DIGIT (DIGIT)
  ) u_digito (
    .A    (a_q[DIGIT-1:0]),
    .B    (b_q[DIGIT-1:0]),
    .Cin  (carry_q),
    .Sum  (w_dsum),
    .Cout (w_dcout)
  );

  assign w_last = (cnt_q == CW'(N - 1));

  // Partial-sum shift register: only the N-1 earlier digits need storing,
  // the newest digit comes straight from the adder.
  if (N > 1) begin : g_shift
    logic [WIDTH-DIGIT-1:0] res_q;

    assign w_full = {w_dsum, res_q};

    // Shift each new digit in from the top while running.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        res_q <= '0;
      end else if (state_q == ST_RUN) begin
        res_q <= w_full[WIDTH-1:DIGIT];
      end
    end
  end else begin : g_noshift
    assign w_full = w_dsum;
  end

  // Next-state and datapath control.
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    carry_d = carry_q;
    cnt_d   = cnt_q;
    a_msb_d = a_msb_q;
    b_msb_d = b_msb_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    done_d  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          a_d     = A;
          b_d     = Sub ? ~B : B;
          carry_d = Sub ? 1'b1 : Cin;
          cnt_d   = '0;
          a_msb_d = A[WIDTH-1];
          b_msb_d = Sub ? ~B[WIDTH-1] : B[WIDTH-1];
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        a_d     = a_q >> DIGIT;
        b_d     = b_q >> DIGIT;
        carry_d = w_dcout;
        cnt_d   = cnt_q + CW'(1);
        if (w_last) begin
          sum_d   = w_full;
          cout_d  = w_dcout;
          ovf_d   = (a_msb_q == b_msb_q) && (w_full[WIDTH-1] != a_msb_q);
          done_d  = 1'b1;
          state_d = ST_IDLE;
        end
      end
    endcase
  end

  // State and datapath registers with asynchronous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
      a_msb_q <= 1'b0;
      b_msb_q <= 1'b0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      carry_q <= carry_d;
      cnt_q   <= cnt_d;
      a_msb_q <= a_msb_d;
      b_msb_q <= b_msb_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
      done_q  <= done_d;
    end
  end

  assign ready = (state_q == ST_IDLE);
  assign done  = done_q;
  assign Sum   = sum_q;
  assign Cout  = cout_q;
  assign Ovf   = ovf_q;

endmodule
`default_nettype wire
